vga_capture_decoder: RTL

VGA_CAPTURE_DECODER -- requirements
Module: vga_capture_decoder

---
 rtl/vga_capture_decoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_capture_decoder.sv
// Recovers hpos/vpos/pixel from async VGA syncs and locks onto stable timing.
// Latency: 3 clocks input->o_pixel/o_hpos; no backpressure, streams every clock.
module vga_capture_decoder #(
  parameter int H_TOTAL      = 800,
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int V_TOTAL      = 525,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_vga_hsync,
  input  logic       i_vga_vsync,
  input  logic [2:0] i_vga_r,
  input  logic [2:0] i_vga_g,
  input  logic [2:0] i_vga_b,
  output logic [9:0] o_hpos,
  output logic [9:0] o_vpos,
  output logic [8:0] o_pixel,
  output logic       o_pixel_valid,
  output logic       o_locked,
  output logic       o_err,
  output logic [9:0] o_line_len,
  output logic [9:0] o_frame_lines
);

  localparam logic [9:0] C_H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_SYNC  = 10'(H_SYNC_START);
  localparam logic [9:0] C_V_SYNC  = 10'(V_SYNC_START);
  localparam logic [9:0] C_H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] C_V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] C_H_TOTAL = 10'(H_TOTAL);
  localparam logic [9:0] C_V_TOTAL = 10'(V_TOTAL);
  localparam logic [9:0] C_TIMEOUT = 10'(H_TOTAL + 16);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t     r_state;
  logic       r_hs_s1, r_hs_s2, r_hs_d;
  logic       r_vs_s1, r_vs_s2, r_vs_d;
  logic [8:0] r_pix0, r_pix1;
  logic [9:0] r_lcnt, r_fcnt, r_meas_lines;
  logic       r_line_err, r_timing;

  logic       w_hs_fall, w_vs_fall, w_h_wrap;
  logic [9:0] w_hpos_inc, w_vpos_inc, w_hpos_nxt, w_vpos_nxt;
  logic [9:0] w_lcnt_inc, w_fcnt_inc;
  logic       w_loss, w_go_lock, w_lock_nxt;

  assign w_hs_fall  = r_hs_d & ~r_hs_s2;
  assign w_vs_fall  = r_vs_d & ~r_vs_s2;
  assign w_h_wrap   = (o_hpos == C_H_LAST);
  assign w_hpos_inc = w_h_wrap ? 10'd0 : o_hpos + 10'd1;
  assign w_vpos_inc = !w_h_wrap ? o_vpos : ((o_vpos == C_V_LAST) ? 10'd0 : o_vpos + 10'd1);
  assign w_hpos_nxt = w_hs_fall ? C_H_SYNC : w_hpos_inc;
  assign w_vpos_nxt = w_vs_fall ? C_V_SYNC : w_vpos_inc;
  assign w_lcnt_inc = (r_lcnt == 10'h3FF) ? r_lcnt : r_lcnt + 10'd1;
  assign w_fcnt_inc = (r_fcnt == 10'h3FF) ? r_fcnt : r_fcnt + 10'd1;

  // Lock is judged against the free-running counters, before any sync reload.
  assign w_loss = (r_state == LOCKED) &&
                  ((w_hs_fall && (w_hpos_inc != C_H_SYNC)) ||
                   (w_vs_fall && (w_vpos_inc != C_V_SYNC)) ||
                   (!w_hs_fall && (r_lcnt >= C_TIMEOUT)));
  assign w_go_lock  = (r_state == MEASURE) && w_vs_fall &&
                      (r_meas_lines == C_V_TOTAL) && !r_line_err;
  assign w_lock_nxt = ((r_state == LOCKED) && !w_loss) || w_go_lock;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs_s1 <= 1'b1;
      r_hs_s2 <= 1'b1;
      r_hs_d  <= 1'b1;
      r_vs_s1 <= 1'b1;
      r_vs_s2 <= 1'b1;
      r_vs_d  <= 1'b1;
      r_pix0  <= '0;
      r_pix1  <= '0;
      o_pixel <= '0;
      o_hpos  <= '0;
      o_vpos  <= '0;
    end else begin
      r_hs_s1 <= i_vga_hsync;
      r_hs_s2 <= r_hs_s1;
      r_hs_d  <= r_hs_s2;
      r_vs_s1 <= i_vga_vsync;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;
      r_pix0  <= {i_vga_r, i_vga_g, i_vga_b};
      r_pix1  <= r_pix0;
      o_pixel <= r_pix1;
      o_hpos  <= w_hpos_nxt;
      o_vpos  <= w_vpos_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lcnt        <= '0;
      r_fcnt        <= '0;
      o_line_len    <= '0;
      o_frame_lines <= '0;
    end else begin
      r_lcnt <= w_hs_fall ? 10'd1 : w_lcnt_inc;
      if (w_hs_fall) o_line_len <= r_lcnt;
      if (w_vs_fall) begin
        o_frame_lines <= r_fcnt;
        r_fcnt        <= w_hs_fall ? 10'd1 : 10'd0;
      end else if (w_hs_fall) begin
        r_fcnt <= w_fcnt_inc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= SEARCH;
      r_meas_lines  <= '0;
      r_line_err    <= 1'b0;
      r_timing      <= 1'b0;
      o_locked      <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_err         <= w_loss;
      o_locked      <= w_lock_nxt;
      o_pixel_valid <= w_lock_nxt && (w_hpos_nxt < C_H_VIS) && (w_vpos_nxt < C_V_VIS);
      case (r_state)
        SEARCH: begin
          if (w_vs_fall) begin
            r_state      <= MEASURE;
            r_meas_lines <= '0;
            r_line_err   <= 1'b0;
            r_timing     <= 1'b0;
          end
        end
        MEASURE: begin
          if (w_vs_fall) begin
            r_state      <= w_go_lock ? LOCKED : MEASURE;
            r_meas_lines <= '0;
            r_line_err   <= 1'b0;
            r_timing     <= 1'b0;
          end else if (w_hs_fall) begin
            // First fall after a frame boundary only arms the interval timer.
            r_meas_lines <= (r_meas_lines == 10'h3FF) ? r_meas_lines : r_meas_lines + 10'd1;
            r_timing     <= 1'b1;
            if (r_timing && (r_lcnt != C_H_TOTAL)) r_line_err <= 1'b1;
          end
        end
        LOCKED: begin
          if (w_loss) r_state <= SEARCH;
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

endmodule
